// File: rtl/mix_pkg.sv
// Shared constants, FSM state type and saturation helper for the frame mixer.
package mix_pkg;

    localparam int unsigned DATA_BITS      = 24;
    localparam int unsigned GAIN_FRAC_BITS = 14;
    localparam logic [15:0] GAIN_RESET     = 16'h2000;

    localparam logic signed [DATA_BITS-1:0] SAT_MAX = {1'b0, {(DATA_BITS-1){1'b1}}};
    localparam logic signed [DATA_BITS-1:0] SAT_MIN = {1'b1, {(DATA_BITS-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMacL, StMacR, StOut} state_e;

    typedef struct packed {
        logic               clip;
        logic signed [63:0] val;
    } sat_t;

    // Clamp a wide signed value into a signed field of `bits` width.
    function automatic sat_t saturate(input logic signed [63:0] val, input int unsigned bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               res;
        hi       = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo       = -(64'sd1 <<< (bits - 1));
        res.clip = 1'b1;
        if (val > hi) begin
            res.val = hi;
        end else if (val < lo) begin
            res.val = lo;
        end else begin
            res.val  = val;
            res.clip = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/mix_scheduler_if.sv
// Sample capture, control and mixed-output signals between the I2S receivers and the mixer.
interface mix_scheduler_if #(
    parameter int unsigned NUM_DEV   = 2,
    parameter int unsigned DATA_BITS = 24,
    parameter int unsigned GAIN_BITS = 16
);
    logic [NUM_DEV-1:0]           in_valid;
    logic [NUM_DEV-1:0]           in_left_rightn;
    logic [NUM_DEV*DATA_BITS-1:0] in_data;
    logic                         frame_start;
    logic                         gain_wr_en;
    logic [2:0]                   gain_wr_addr;
    logic [GAIN_BITS-1:0]         gain_wr_data;
    logic [NUM_DEV-1:0]           mute;
    logic                         overrun_clr;
    logic [DATA_BITS-1:0]         mix_l;
    logic [DATA_BITS-1:0]         mix_r;
    logic                         mix_valid;
    logic                         busy;
    logic                         clip_l;
    logic                         clip_r;
    logic                         overrun;

    modport master (
        output in_valid, in_left_rightn, in_data, frame_start, gain_wr_en, gain_wr_addr,
               gain_wr_data, mute, overrun_clr,
        input  mix_l, mix_r, mix_valid, busy, clip_l, clip_r, overrun
    );

    modport slave (
        input  in_valid, in_left_rightn, in_data, frame_start, gain_wr_en, gain_wr_addr,
               gain_wr_data, mute, overrun_clr,
        output mix_l, mix_r, mix_valid, busy, clip_l, clip_r, overrun
    );

endinterface

// File: rtl/mix_mac.sv
// Registered signed multiply-accumulate with Q2.14 gain, plus shift/saturate of the running sum.
module mix_mac #(
    parameter int unsigned NUM_DEV   = 2,
    parameter int unsigned DATA_BITS = mix_pkg::DATA_BITS,
    parameter int unsigned GAIN_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 mute_i,
    input  logic [DATA_BITS-1:0] sample_i,
    input  logic [GAIN_BITS-1:0] gain_i,
    output logic [DATA_BITS-1:0] result_o,
    output logic                 clip_o
);
    import mix_pkg::*;

    localparam int unsigned ProdW = DATA_BITS + GAIN_BITS + 1;
    localparam int unsigned AccW  = ProdW + $clog2(NUM_DEV);

    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0]  acc_d, acc_q;
    logic signed [63:0]      acc_shr;
    sat_t                    sat;
    logic                    unused_sat_hi;

    always_comb begin
        prod = mute_i ? '0 :
               ProdW'($signed(sample_i)) * ProdW'($signed({1'b0, gain_i}));
        // Clear and accumulate in the same cycle so channel changeover costs no extra cycle.
        acc_d = clr_i ? '0 : acc_q;
        if (en_i) begin
            acc_d = acc_d + AccW'(prod);
        end
        acc_shr       = 64'(acc_q) >>> GAIN_FRAC_BITS;
        sat           = saturate(acc_shr, DATA_BITS);
        result_o      = sat.val[DATA_BITS-1:0];
        clip_o        = sat.clip;
        unused_sat_hi = ^sat.val[63:DATA_BITS];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mix_scheduler.sv
// Frame mixer: captures per-device samples, snapshots on frame_start and steps one MAC over
// all devices (left then right) to produce a saturated gain-weighted stereo sample.
module mix_scheduler #(
    parameter int unsigned NUM_DEV   = 2,
    parameter int unsigned DATA_BITS = mix_pkg::DATA_BITS,
    parameter int unsigned GAIN_BITS = 16
) (
    input logic           clk,
    input logic           rstn,
    mix_scheduler_if.slave bus
);
    import mix_pkg::*;

    localparam int unsigned IdxW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    logic [DATA_BITS-1:0] l_cap_d[NUM_DEV], l_cap_q[NUM_DEV];
    logic [DATA_BITS-1:0] r_cap_d[NUM_DEV], r_cap_q[NUM_DEV];
    logic [DATA_BITS-1:0] l_work_d[NUM_DEV], l_work_q[NUM_DEV];
    logic [DATA_BITS-1:0] r_work_d[NUM_DEV], r_work_q[NUM_DEV];
    logic [GAIN_BITS-1:0] gain_d[NUM_DEV], gain_q[NUM_DEV];
    logic [GAIN_BITS-1:0] gain_work_d[NUM_DEV], gain_work_q[NUM_DEV];
    logic [NUM_DEV-1:0]   mute_work_d, mute_work_q;
    state_e               state_d, state_q;
    logic [IdxW-1:0]      idx_d, idx_q;
    logic [DATA_BITS-1:0] l_res_d, l_res_q, mix_l_d, mix_l_q, mix_r_d, mix_r_q;
    logic                 l_clip_d, l_clip_q, clip_l_d, clip_l_q, clip_r_d, clip_r_q;
    logic                 mix_valid_d, mix_valid_q, overrun_d, overrun_q;
    logic                 mac_clr, mac_en, mac_mute, mac_clip, last_dev;
    logic [DATA_BITS-1:0] mac_sample, mac_result;
    logic [GAIN_BITS-1:0] mac_gain;

    mix_mac #(
        .NUM_DEV  (NUM_DEV),
        .DATA_BITS(DATA_BITS),
        .GAIN_BITS(GAIN_BITS)
    ) u_mac (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .clr_i   (mac_clr),
        .en_i    (mac_en),
        .mute_i  (mac_mute),
        .sample_i(mac_sample),
        .gain_i  (mac_gain),
        .result_o(mac_result),
        .clip_o  (mac_clip)
    );

    always_comb begin
        l_cap_d     = l_cap_q;
        r_cap_d     = r_cap_q;
        l_work_d    = l_work_q;
        r_work_d    = r_work_q;
        gain_d      = gain_q;
        gain_work_d = gain_work_q;
        mute_work_d = mute_work_q;
        state_d     = state_q;
        idx_d       = idx_q;
        l_res_d     = l_res_q;
        l_clip_d    = l_clip_q;
        mix_l_d     = mix_l_q;
        mix_r_d     = mix_r_q;
        clip_l_d    = clip_l_q;
        clip_r_d    = clip_r_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        last_dev    = (idx_q == IdxW'(NUM_DEV - 1));
        mac_sample  = (state_q == StMacR) ? r_work_q[idx_q] : l_work_q[idx_q];
        mac_gain    = gain_work_q[idx_q];
        mac_mute    = mute_work_q[idx_q];

        for (int i = 0; i < NUM_DEV; i++) begin
            if (bus.in_valid[i]) begin
                if (bus.in_left_rightn[i]) begin
                    l_cap_d[i] = bus.in_data[i*DATA_BITS +: DATA_BITS];
                end else begin
                    r_cap_d[i] = bus.in_data[i*DATA_BITS +: DATA_BITS];
                end
            end
        end
        if (bus.gain_wr_en && (32'(bus.gain_wr_addr) < NUM_DEV)) begin
            gain_d[bus.gain_wr_addr[IdxW-1:0]] = bus.gain_wr_data;
        end
        // Set has priority over clear when both happen in one cycle.
        if (bus.frame_start && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.frame_start) begin
                    l_work_d    = l_cap_q;
                    r_work_d    = r_cap_q;
                    gain_work_d = gain_q;
                    mute_work_d = bus.mute;
                    mac_clr     = 1'b1;
                    idx_d       = '0;
                    state_d     = StMacL;
                end
            end
            StMacL: begin
                mac_en = 1'b1;
                idx_d  = last_dev ? '0 : idx_q + 1'b1;
                if (last_dev) begin
                    state_d = StMacR;
                end
            end
            StMacR: begin
                mac_en = 1'b1;
                // Accumulator still holds the finished left sum on the first right-channel step.
                if (idx_q == '0) begin
                    mac_clr  = 1'b1;
                    l_res_d  = mac_result;
                    l_clip_d = mac_clip;
                end
                idx_d = last_dev ? '0 : idx_q + 1'b1;
                if (last_dev) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                mix_l_d     = l_res_q;
                clip_l_d    = l_clip_q;
                mix_r_d     = mac_result;
                clip_r_d    = mac_clip;
                mix_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_DEV; i++) begin
                l_cap_q[i]     <= '0;
                r_cap_q[i]     <= '0;
                l_work_q[i]    <= '0;
                r_work_q[i]    <= '0;
                gain_q[i]      <= GAIN_BITS'(GAIN_RESET);
                gain_work_q[i] <= '0;
            end
            mute_work_q <= '0;
            state_q     <= StIdle;
            idx_q       <= '0;
            l_res_q     <= '0;
            l_clip_q    <= 1'b0;
            mix_l_q     <= '0;
            mix_r_q     <= '0;
            clip_l_q    <= 1'b0;
            clip_r_q    <= 1'b0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            l_cap_q     <= l_cap_d;
            r_cap_q     <= r_cap_d;
            l_work_q    <= l_work_d;
            r_work_q    <= r_work_d;
            gain_q      <= gain_d;
            gain_work_q <= gain_work_d;
            mute_work_q <= mute_work_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            l_res_q     <= l_res_d;
            l_clip_q    <= l_clip_d;
            mix_l_q     <= mix_l_d;
            mix_r_q     <= mix_r_d;
            clip_l_q    <= clip_l_d;
            clip_r_q    <= clip_r_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.mix_l     = mix_l_q;
    assign bus.mix_r     = mix_r_q;
    assign bus.clip_l    = clip_l_q;
    assign bus.clip_r    = clip_r_q;
    assign bus.mix_valid = mix_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mix_scheduler.sv
// Self-checking bench for mix_scheduler: fixed vector table, corner sequences and random traffic
// checked every cycle against a frame-level arithmetic model.
module tb_mix_scheduler;
    localparam int unsigned N   = 2;
    localparam int unsigned DB  = 24;
    localparam int unsigned GB  = 16;
    localparam int          LAT = 2 * N + 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mix_scheduler_if #(.NUM_DEV(N), .DATA_BITS(DB), .GAIN_BITS(GB)) bus ();

    mix_scheduler #(.NUM_DEV(N), .DATA_BITS(DB), .GAIN_BITS(GB)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    typedef struct {
        logic [DB-1:0] l0, l1, r0, r1;
        bit            wr_gain;
        logic [GB-1:0] g0, g1;
        logic [N-1:0]  mu;
        logic [DB-1:0] xl, xr;
        logic          xcl, xcr;
    } vec_t;

    int n_vec = 0, n_err = 0, cyc = 0, acc_cyc = -1, n_valid = 0;
    longint m_l[N], m_r[N], m_g[N];
    logic m_ovr;
    logic [DB-1:0] p_l, p_r, e_l, e_r;
    logic p_cl, p_cr, e_cl, e_cr, e_valid, e_busy;

    // Frame result: sum(sample*gain) over unmuted devices, floor-divided by 2^14, clamped.
    function automatic logic [DB:0] chan(input bit left, input logic [N-1:0] mu);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            if (!mu[i]) s += (left ? m_l[i] : m_r[i]) * m_g[i];
        end
        s = s >>> 14;
        if (s > 64'sd8388607) return {1'b1, 24'h7FFFFF};
        if (s < -64'sd8388608) return {1'b1, 24'h800000};
        return {1'b0, s[DB-1:0]};
    endfunction

    function automatic bit busy_at(input int c);
        return acc_cyc >= 0 && c >= acc_cyc + 1 && c <= acc_cyc + 2 * N + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_l[i] = 0; m_r[i] = 0; m_g[i] = 64'h2000;
        end
        m_ovr = 0; acc_cyc = -1;
        e_l = '0; e_r = '0; e_cl = 0; e_cr = 0; e_valid = 0; e_busy = 0;
    endtask

    task automatic idle_pulses();
        bus.in_valid = '0; bus.frame_start = 0; bus.gain_wr_en = 0; bus.overrun_clr = 0;
    endtask

    task automatic check(input string name);
        n_vec++;
        if (bus.mix_l !== e_l || bus.mix_r !== e_r || bus.mix_valid !== e_valid ||
            bus.busy !== e_busy || bus.clip_l !== e_cl || bus.clip_r !== e_cr ||
            bus.overrun !== m_ovr) begin
            n_err++;
            $display("FAIL %s cyc=%0d got l=%h r=%h v=%b busy=%b cl=%b cr=%b ovr=%b want l=%h r=%h v=%b busy=%b cl=%b cr=%b ovr=%b",
                     name, cyc, bus.mix_l, bus.mix_r, bus.mix_valid, bus.busy, bus.clip_l,
                     bus.clip_r, bus.overrun, e_l, e_r, e_valid, e_busy, e_cl, e_cr, m_ovr);
        end
    endtask

    // Apply current inputs for one clock, advance the model, then compare all outputs.
    task automatic tick(input string name);
        bit bz;
        logic [DB:0] t;
        bz = busy_at(cyc);
        if (bus.frame_start) begin
            if (bz) m_ovr = 1;
            else begin
                acc_cyc = cyc;
                t = chan(1, bus.mute); p_cl = t[DB]; p_l = t[DB-1:0];
                t = chan(0, bus.mute); p_cr = t[DB]; p_r = t[DB-1:0];
            end
        end
        if (!(bus.frame_start && bz) && bus.overrun_clr) m_ovr = 0;
        for (int i = 0; i < N; i++) begin
            if (bus.in_valid[i]) begin
                if (bus.in_left_rightn[i]) m_l[i] = longint'($signed(bus.in_data[i*DB +: DB]));
                else m_r[i] = longint'($signed(bus.in_data[i*DB +: DB]));
            end
        end
        if (bus.gain_wr_en && bus.gain_wr_addr < N) m_g[bus.gain_wr_addr] = longint'(bus.gain_wr_data);
        @(posedge clk); #1; cyc++;
        idle_pulses();
        e_busy  = busy_at(cyc);
        e_valid = acc_cyc >= 0 && cyc == acc_cyc + LAT;
        if (e_valid) begin
            e_l = p_l; e_r = p_r; e_cl = p_cl; e_cr = p_cr;
        end
        if (bus.mix_valid) n_valid++;
        check(name);
    endtask

    task automatic reset_cycles(input int n);
        rstn = 0; #1;
        model_reset();
        check("reset_async");
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1; cyc++;
            check("reset_hold");
        end
        rstn = 1;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        bus.in_valid = '1; bus.in_left_rightn = '1; bus.in_data = {v.l1, v.l0}; tick("cap_l");
        bus.in_valid = '1; bus.in_left_rightn = '0; bus.in_data = {v.r1, v.r0}; tick("cap_r");
        if (v.wr_gain) begin
            bus.gain_wr_en = 1; bus.gain_wr_addr = 3'd0; bus.gain_wr_data = v.g0; tick("gain0");
            bus.gain_wr_en = 1; bus.gain_wr_addr = 3'd1; bus.gain_wr_data = v.g1; tick("gain1");
        end
        bus.mute = v.mu; bus.frame_start = 1; tick("frame");
        lat = 1;
        while (!bus.mix_valid && lat < 20) begin
            tick("wait");
            lat++;
        end
        n_vec++;
        if (lat != LAT || bus.mix_l !== v.xl || bus.mix_r !== v.xr ||
            bus.clip_l !== v.xcl || bus.clip_r !== v.xcr) begin
            n_err++;
            $display("FAIL %s got lat=%0d l=%h r=%h cl=%b cr=%b want lat=%0d l=%h r=%h cl=%b cr=%b",
                     name, lat, bus.mix_l, bus.mix_r, bus.clip_l, bus.clip_r, LAT, v.xl, v.xr,
                     v.xcl, v.xcr);
        end
        tick("post");
    endtask

    function automatic logic [DB-1:0] pick_sample();
        case ($urandom_range(0, 3))
            0: return 24'h7FFFFF;
            1: return 24'h800000;
            default: return DB'($urandom);
        endcase
    endfunction

    vec_t tbl[6];

    initial begin
        tbl[0] = '{24'h100000, 24'h200000, 24'h0, 24'h0, 0, 16'h0, 16'h0, 2'b00,
                   24'h180000, 24'h0, 0, 0};
        tbl[1] = '{24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'h800000, 1, 16'h4000, 16'h4000, 2'b00,
                   24'h7FFFFF, 24'h800000, 1, 1};
        tbl[2] = '{24'h0, 24'h100000, 24'hFFFFF0, 24'h123456, 1, 16'h8000, 16'h4000, 2'b10,
                   24'h0, 24'hFFFFE0, 0, 0};
        tbl[3] = '{24'h7FFFFF, 24'hFFFFFF, 24'h000003, 24'hFFFFFD, 1, 16'h0, 16'h4000, 2'b00,
                   24'hFFFFFF, 24'hFFFFFD, 0, 0};
        tbl[4] = '{24'hFFFFFF, 24'h0, 24'h000001, 24'h0, 1, 16'h2000, 16'h2000, 2'b00,
                   24'hFFFFFF, 24'h0, 0, 0};
        tbl[5] = '{24'h7FFFFF, 24'h0, 24'h800000, 24'h0, 1, 16'h4000, 16'h4000, 2'b00,
                   24'h7FFFFF, 24'h800000, 0, 0};

        idle_pulses();
        bus.in_left_rightn = '0; bus.in_data = '0; bus.gain_wr_addr = '0;
        bus.gain_wr_data = '0; bus.mute = '0;
        reset_cycles(3);
        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Second frame_start at T+3 is dropped and flags overrun; set beats a same-cycle clear.
        n_valid = 0;
        bus.frame_start = 1; tick("ovr_t0");
        tick("ovr_t1"); tick("ovr_t2");
        bus.frame_start = 1; tick("ovr_t3");
        for (int i = 0; i < 6; i++) tick("ovr_drain");
        n_vec++;
        if (n_valid != 1) begin
            n_err++;
            $display("FAIL ovr_single_valid got %0d pulses want 1", n_valid);
        end
        bus.overrun_clr = 1; tick("ovr_clr");
        bus.frame_start = 1; tick("ovr2_t0");
        bus.frame_start = 1; bus.overrun_clr = 1; tick("ovr_set_wins");
        for (int i = 0; i < 6; i++) tick("ovr2_drain");
        bus.overrun_clr = 1; tick("ovr_clr2");

        // New sample with the accepted frame_start, and a gain write mid-mix, apply next frame.
        bus.mute = '0;
        bus.frame_start = 1; bus.in_valid = 2'b01; bus.in_left_rightn = 2'b01;
        bus.in_data = {24'h0, 24'h400000}; tick("late_t0");
        tick("late_t1");
        bus.gain_wr_en = 1; bus.gain_wr_addr = 3'd0; bus.gain_wr_data = 16'h1000; tick("late_t2");
        for (int i = 0; i < 5; i++) tick("late_drain");
        bus.frame_start = 1; tick("late_next");
        for (int i = 0; i < 7; i++) tick("late_next_drain");

        // Reset mid-mix aborts with no mix_valid afterwards.
        bus.frame_start = 1; tick("rst_t0");
        tick("rst_t1"); tick("rst_t2");
        reset_cycles(2);
        n_valid = 0;
        for (int i = 0; i < 8; i++) tick("rst_after");
        n_vec++;
        if (n_valid != 0) begin
            n_err++;
            $display("FAIL rst_abort got %0d pulses want 0", n_valid);
        end

        for (int k = 0; k < 600; k++) begin
            bus.in_valid = N'($urandom);
            bus.in_left_rightn = N'($urandom);
            for (int i = 0; i < N; i++) bus.in_data[i*DB +: DB] = pick_sample();
            bus.frame_start = ($urandom_range(0, 5) == 0);
            bus.gain_wr_en = ($urandom_range(0, 4) == 0);
            bus.gain_wr_addr = 3'($urandom_range(0, 7));
            bus.gain_wr_data = ($urandom_range(0, 3) == 0) ? 16'h0 : GB'($urandom);
            if ($urandom_range(0, 7) == 0) bus.mute = N'($urandom);
            bus.overrun_clr = ($urandom_range(0, 9) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
